br_wb_arbiter: RTL

Write-port controller for the 32×32 register bank, which has a single write port and no reset of its own. After reset it runs a clear sweep that writes zero to registers x1..x31. It then shares the write port among N writeback requesters (e.g. ALU, load unit) using round-robin arbitration with a valid/ready handshake. It drives the bank's write address, write data and write enable directly from registers.

---
 rtl/br_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/br_wb_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared constants and types for the register-bank write-port controller
package br_pkg;
  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int REG_COUNT = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting after the last winner
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic w_found;
  int   w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    // Scan last+1 .. last+N so the previous winner is considered last
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(last) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found       = 1'b1;
        grant[w_idx]  = 1'b1;
        grant_idx     = IW'(w_idx);
      end
    end
  end
endmodule

// File: rtl/br_wb_arbiter.sv
// rtl/br_wb_arbiter.sv - register-bank write port: post-reset clear sweep, then round-robin writeback arbitration
module br_wb_arbiter
  import br_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = br_pkg::AW,
  parameter int DW = br_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic [AW-1:0]   a3,
  output logic [DW-1:0]   wd3,
  output logic            we,
  output logic            init_done
);
  localparam int IW = $clog2(N);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_last, w_last_nxt;
  logic [AW-1:0] r_a3, w_a3_nxt;
  logic [DW-1:0] r_wd3, w_wd3_nxt;
  logic          r_we, w_we_nxt;
  logic          r_init_done, w_init_done_nxt;

  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_grant_idx;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req       (req_valid),
    .last      (r_last),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && r_cnt == AW'(REG_COUNT - 1)) w_state_nxt = RUN;
  end

  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_a3_nxt        = r_a3;
    w_wd3_nxt       = r_wd3;
    w_we_nxt        = 1'b0;
    w_init_done_nxt = r_init_done;
    req_ready       = '0;
    case (r_state)
      CLEAR: begin
        w_we_nxt  = 1'b1;
        w_a3_nxt  = r_cnt;
        w_wd3_nxt = '0;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AW'(REG_COUNT - 1)) w_init_done_nxt = 1'b1;
      end
      RUN: begin
        req_ready = w_grant;
        // x0 writes are consumed but never reach the bank
        if (|w_grant) begin
          w_a3_nxt   = w_addr;
          w_wd3_nxt  = w_data;
          w_we_nxt   = (w_addr != AW'(ZERO_REG));
          w_last_nxt = w_grant_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= AW'(1);
      r_last      <= IW'(N - 1);
      r_a3        <= '0;
      r_wd3       <= '0;
      r_we        <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_a3        <= w_a3_nxt;
      r_wd3       <= w_wd3_nxt;
      r_we        <= w_we_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  assign a3        = r_a3;
  assign wd3       = r_wd3;
  assign we        = r_we;
  assign init_done = r_init_done;
endmodule
